// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus arbiter: FSM state encodings, requester
// indices, default bus widths and a state-to-grant decode helper.
package cpu_bus_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned N_REQ      = 3;
    localparam int unsigned ST_W       = 3;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_OWN_DMA = 3'd1;
    localparam logic [2:0] ST_OWN_IRQ = 3'd2;
    localparam logic [2:0] ST_OWN_IE  = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;

    // Requester indices into the grant vector
    localparam logic [1:0] DMA = 2'd0;
    localparam logic [1:0] IRQ = 2'd1;
    localparam logic [1:0] IE  = 2'd2;

    // One-hot grant vector owned by a given state; zero in IDLE and GAP
    function automatic logic [N_REQ-1:0] gnt_of_state(input logic [ST_W-1:0] st);
        logic [N_REQ-1:0] g;
        g = '0;
        case (st)
            ST_OWN_DMA: g[DMA] = 1'b1;
            ST_OWN_IRQ: g[IRQ] = 1'b1;
            ST_OWN_IE:  g[IE]  = 1'b1;
            default:    g      = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/cpu_bus_mux.sv
// Combinational 3:1 bus mux keyed by the registered grant vector.
// Ports:
//   gnt                       grant vector, one-hot or all-zero (index DMA/IRQ/IE)
//   dma_* / irq_* / ie_*      requester address, write data, write enable
//   addr_c / wdata_c / we_c   selected bus signals; all zero when no grant is active
module cpu_bus_mux
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [N_REQ-1:0]  gnt,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] irq_addr,
    input  logic [DATA_W-1:0] irq_wdata,
    input  logic              irq_we,
    input  logic [ADDR_W-1:0] ie_addr,
    input  logic [DATA_W-1:0] ie_wdata,
    input  logic              ie_we,
    output logic [ADDR_W-1:0] addr_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic              we_c
);

    // Grant is one-hot, so the if-chain order carries no priority meaning
    always_comb begin
        addr_c  = '0;
        wdata_c = '0;
        we_c    = 1'b0;
        if (gnt[DMA]) begin
            addr_c  = dma_addr;
            wdata_c = dma_wdata;
            we_c    = dma_we;
        end else if (gnt[IRQ]) begin
            addr_c  = irq_addr;
            wdata_c = irq_wdata;
            we_c    = irq_we;
        end else if (gnt[IE]) begin
            addr_c  = ie_addr;
            wdata_c = ie_wdata;
            we_c    = ie_we;
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// CPU memory bus arbiter for the OAM DMA engine, interrupt handler and
// instruction engine. Non-preemptive fixed priority (DMA > IRQ > IE), a dead
// GAP cycle on every ownership change, and DMA grants aligned so the first
// DMA-owned cycle is always an even CPU cycle.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   {dma,irq,ie}_req/addr/wdata/we requester bus requests and payloads
//   {dma,irq,ie}_gnt               registered grants, one-hot or all-zero
//   halt_ie, halt_irq              stall outputs: requesting but not granted
//   mem_addr/mem_wdata/mem_we      bus to the CPU address space
//   mem_rdata -> rdata             read data broadcast to all masters
//   cyc_par                        CPU cycle parity, toggles every clk
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_we,
    input  logic              irq_req,
    input  logic [ADDR_W-1:0] irq_addr,
    input  logic [DATA_W-1:0] irq_wdata,
    input  logic              irq_we,
    input  logic              ie_req,
    input  logic [ADDR_W-1:0] ie_addr,
    input  logic [DATA_W-1:0] ie_wdata,
    input  logic              ie_we,
    output logic              dma_gnt,
    output logic              irq_gnt,
    output logic              ie_gnt,
    output logic              halt_ie,
    output logic              halt_irq,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              cyc_par
);

    logic [ST_W-1:0]  state_q,   state_d;
    logic [N_REQ-1:0] gnt_q,     gnt_d;
    logic             cyc_par_q, cyc_par_d;

    // State, grant and parity registers; reset drops grants asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            cyc_par_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cyc_par_q <= cyc_par_d;
        end
    end

    // Next-state logic; owners are never preempted, decisions happen only in IDLE/GAP
    always_comb begin
        state_d   = state_q;
        cyc_par_d = ~cyc_par_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (dma_req) begin
                    // Entering on an odd cycle makes the first DMA-owned cycle even.
                    // Holding here blocks lower requesters so DMA cannot starve.
                    state_d = cyc_par_q ? ST_OWN_DMA : ST_IDLE;
                end else if (irq_req) begin
                    state_d = ST_OWN_IRQ;
                end else if (ie_req) begin
                    state_d = ST_OWN_IE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN_DMA: if (!dma_req) state_d = ST_GAP;
            ST_OWN_IRQ: if (!irq_req) state_d = ST_GAP;
            ST_OWN_IE:  if (!ie_req)  state_d = ST_GAP;
            default:    state_d = ST_IDLE;
        endcase
        gnt_d = gnt_of_state(state_d);
    end

    assign dma_gnt = gnt_q[DMA];
    assign irq_gnt = gnt_q[IRQ];
    assign ie_gnt  = gnt_q[IE];
    assign cyc_par = cyc_par_q;

    // Stalls are combinational so a master halts in the same cycle it requests
    assign halt_ie  = ie_req  && !gnt_q[IE];
    assign halt_irq = irq_req && !gnt_q[IRQ];

    // Synchronous memory already delivers data one cycle after the address
    assign rdata = mem_rdata;

    cpu_bus_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .gnt       (gnt_q),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_we    (dma_we),
        .irq_addr  (irq_addr),
        .irq_wdata (irq_wdata),
        .irq_we    (irq_we),
        .ie_addr   (ie_addr),
        .ie_wdata  (ie_wdata),
        .ie_we     (ie_we),
        .addr_c    (mem_addr),
        .wdata_c   (mem_wdata),
        .we_c      (mem_we)
    );

endmodule
